// File: rtl/ising_config.sv
// Shared configuration package for the PS-to-PL configuration path.
// Holds the GPIO bus field positions, the register address map and the
// indirect lookup-table map used by gpio_cfg_decoder.
package ising_config;

  // GPIO bus layout: w_clk at bit 24, data at 23:16, addr at 15:0.
  localparam int GPIO_WCLK_BIT = 24;
  localparam int GPIO_DATA_LSB = 16;
  localparam int GPIO_ADDR_LSB = 0;

  // Direct-action registers.
  localparam logic [15:0] REG_RUN_TRIG = 16'h0000;
  localparam logic [15:0] REG_DEL_TRIG = 16'h0001;
  localparam logic [15:0] REG_HALT     = 16'h0002;
  localparam logic [15:0] REG_ADC_RUN  = 16'h0005;

  // Indirect table access: each table has a pointer register and a data
  // register; a data write stores at the pointer and then advances it.
  localparam logic [15:0] REG_TBL_A_PTR        = 16'h0015;
  localparam logic [15:0] REG_TBL_A_DATA       = 16'h0016;
  localparam logic [15:0] REG_TBL_A_NL_PTR     = 16'h0027;
  localparam logic [15:0] REG_TBL_A_NL_DATA    = 16'h0028;
  localparam logic [15:0] REG_TBL_B_PTR        = 16'h001A;
  localparam logic [15:0] REG_TBL_B_DATA       = 16'h001B;
  localparam logic [15:0] REG_TBL_C_PTR        = 16'h001F;
  localparam logic [15:0] REG_TBL_C_DATA       = 16'h0020;
  localparam logic [15:0] REG_TBL_MAC_DRV_PTR  = 16'h000C;
  localparam logic [15:0] REG_TBL_MAC_DRV_DATA = 16'h000D;
  localparam logic [15:0] REG_TBL_NL_DRV_PTR   = 16'h000F;
  localparam logic [15:0] REG_TBL_NL_DRV_DATA  = 16'h0010;

  typedef enum logic [2:0] {
    TBL_A,
    TBL_A_NL,
    TBL_B,
    TBL_C,
    TBL_MAC_DRV,
    TBL_NL_DRV
  } tbl_sel_t;

  localparam int NUM_TBLS  = 6;
  localparam int TBL_PTR_W = 8;

  // Result of looking an address up in the table map.
  typedef struct packed {
    logic     hit_ptr;   // address is a table pointer register
    logic     hit_data;  // address is a table data register
    tbl_sel_t sel;       // which table was hit
  } tbl_hit_t;

  // Classify an address against the table map.
  function automatic tbl_hit_t tbl_decode(input logic [15:0] addr);
    tbl_hit_t hit;
    hit = '{hit_ptr: 1'b0, hit_data: 1'b0, sel: TBL_A};
    case (addr)
      REG_TBL_A_PTR:        begin hit.hit_ptr  = 1'b1; hit.sel = TBL_A;       end
      REG_TBL_A_DATA:       begin hit.hit_data = 1'b1; hit.sel = TBL_A;       end
      REG_TBL_A_NL_PTR:     begin hit.hit_ptr  = 1'b1; hit.sel = TBL_A_NL;    end
      REG_TBL_A_NL_DATA:    begin hit.hit_data = 1'b1; hit.sel = TBL_A_NL;    end
      REG_TBL_B_PTR:        begin hit.hit_ptr  = 1'b1; hit.sel = TBL_B;       end
      REG_TBL_B_DATA:       begin hit.hit_data = 1'b1; hit.sel = TBL_B;       end
      REG_TBL_C_PTR:        begin hit.hit_ptr  = 1'b1; hit.sel = TBL_C;       end
      REG_TBL_C_DATA:       begin hit.hit_data = 1'b1; hit.sel = TBL_C;       end
      REG_TBL_MAC_DRV_PTR:  begin hit.hit_ptr  = 1'b1; hit.sel = TBL_MAC_DRV; end
      REG_TBL_MAC_DRV_DATA: begin hit.hit_data = 1'b1; hit.sel = TBL_MAC_DRV; end
      REG_TBL_NL_DRV_PTR:   begin hit.hit_ptr  = 1'b1; hit.sel = TBL_NL_DRV;  end
      REG_TBL_NL_DRV_DATA:  begin hit.hit_data = 1'b1; hit.sel = TBL_NL_DRV;  end
      default: ;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Synchroniser for the asynchronous PS GPIO bus plus rising-edge detection
// of the write-clock bit. All synchroniser and edge-history flops reset to 1,
// so a w_clk that is already high when reset releases never looks like an
// edge: a write needs a synchronised low followed by a high.
// edge_o and bus_o are registered together: bus_o holds the word that was
// on the synchronised bus when the rising edge was seen.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int GPIO_W      = 25,
  parameter int WCLK_BIT    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] bus_o,
  output logic              edge_o
);

  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] bus_q;
  logic              wclk_prev_q;
  logic              edge_q;
  logic              wclk_sync;

  assign wclk_sync = sync_q[SYNC_STAGES-1][WCLK_BIT];

  // Multi-flop synchroniser chain for the whole bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what turns this into a shift chain.
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Rising-edge detect on synchronised w_clk, capturing the bus alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wclk_prev_q <= 1'b1;
      edge_q      <= 1'b0;
      bus_q       <= '1;
    end else begin
      wclk_prev_q <= wclk_sync;
      edge_q      <= wclk_sync & ~wclk_prev_q;
      bus_q       <= sync_q[SYNC_STAGES-1];
    end
  end

  assign bus_o  = bus_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/gpio_cfg_decoder.sv
// Configuration-path front end: synchronises the PS GPIO word, turns each
// w_clk rising edge into one registered register-write strobe, fires the
// trigger pulses, maintains the halt level and performs indirect table
// writes through six independent auto-incrementing 8-bit pointers.
// Optional macro GPIO_WR_LOG_EN adds an accepted-write counter and a
// last-address register; without it those outputs are tied to zero.
module gpio_cfg_decoder
  import ising_config::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GPIO_W      = 25,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              run_trig,
  output logic              del_trig,
  output logic              adc_run,
  output logic              halt,
  output logic              tbl_wr_en,
  output logic [2:0]        tbl_sel,
  output logic [7:0]        tbl_addr,
  output logic [DATA_W-1:0] tbl_data,
  output logic [15:0]       wr_count,
  output logic [ADDR_W-1:0] last_addr
);

  // Captured write from the synchroniser.
  logic [GPIO_W-1:0] cap_bus;
  logic              cap_edge;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              unused_wclk;
  tbl_hit_t          hit;

  gpio_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .GPIO_W      (GPIO_W),
    .WCLK_BIT    (GPIO_WCLK_BIT)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst),
    .gpio_i (gpio_in),
    .bus_o  (cap_bus),
    .edge_o (cap_edge)
  );

  assign cap_addr    = cap_bus[GPIO_ADDR_LSB +: ADDR_W];
  assign cap_data    = cap_bus[GPIO_DATA_LSB +: DATA_W];
  // The w_clk bit has already been consumed by the edge detector.
  assign unused_wclk = cap_bus[GPIO_WCLK_BIT];
  assign hit         = tbl_decode(16'(cap_addr));

  // Output and pointer state.
  logic                 wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q,   wr_data_d;
  logic                 run_trig_q,  run_trig_d;
  logic                 del_trig_q,  del_trig_d;
  logic                 adc_run_q,   adc_run_d;
  logic                 halt_q,      halt_d;
  logic                 tbl_wr_en_q, tbl_wr_en_d;
  tbl_sel_t             tbl_sel_q,   tbl_sel_d;
  logic [TBL_PTR_W-1:0] tbl_addr_q,  tbl_addr_d;
  logic [DATA_W-1:0]    tbl_data_q,  tbl_data_d;
  logic [TBL_PTR_W-1:0] ptr_q [NUM_TBLS];
  logic [TBL_PTR_W-1:0] ptr_d [NUM_TBLS];

  // Decode the captured write into next-cycle strobes and pointer updates.
  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the decode below can leave one unassigned and infer a latch.
    wr_en_d     = 1'b0;
    run_trig_d  = 1'b0;
    del_trig_d  = 1'b0;
    adc_run_d   = 1'b0;
    tbl_wr_en_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    halt_d      = halt_q;
    tbl_sel_d   = tbl_sel_q;
    tbl_addr_d  = tbl_addr_q;
    tbl_data_d  = tbl_data_q;
    ptr_d       = ptr_q;

    if (cap_edge) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = cap_addr;
      wr_data_d  = cap_data;
      run_trig_d = (cap_addr == ADDR_W'(REG_RUN_TRIG));
      del_trig_d = (cap_addr == ADDR_W'(REG_DEL_TRIG));
      adc_run_d  = (cap_addr == ADDR_W'(REG_ADC_RUN));

      if (cap_addr == ADDR_W'(REG_HALT)) begin
        halt_d = cap_data[0];
      end

      if (hit.hit_ptr) begin
        ptr_d[hit.sel] = TBL_PTR_W'(cap_data);
      end

      // Data write stores at the current pointer, then post-increments it
      // (8-bit arithmetic wraps 255 -> 0).
      if (hit.hit_data) begin
        tbl_wr_en_d    = 1'b1;
        tbl_sel_d      = hit.sel;
        tbl_addr_d     = ptr_q[hit.sel];
        tbl_data_d     = cap_data;
        ptr_d[hit.sel] = ptr_q[hit.sel] + TBL_PTR_W'(1);
      end
    end
  end

  // Registered strobes, held write/table fields and the halt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      run_trig_q  <= 1'b0;
      del_trig_q  <= 1'b0;
      adc_run_q   <= 1'b0;
      halt_q      <= 1'b0;
      tbl_wr_en_q <= 1'b0;
      tbl_sel_q   <= TBL_A;
      tbl_addr_q  <= '0;
      tbl_data_q  <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      run_trig_q  <= run_trig_d;
      del_trig_q  <= del_trig_d;
      adc_run_q   <= adc_run_d;
      halt_q      <= halt_d;
      tbl_wr_en_q <= tbl_wr_en_d;
      tbl_sel_q   <= tbl_sel_d;
      tbl_addr_q  <= tbl_addr_d;
      tbl_data_q  <= tbl_data_d;
    end
  end

  // Table pointer array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this small array is reset on purpose - software relies on
      // every pointer starting at 0 - unlike bulk storage, which is
      // normally left unreset so it can map onto RAM.
      for (int i = 0; i < NUM_TBLS; i++) ptr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TBLS; i++) ptr_q[i] <= ptr_d[i];
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign run_trig  = run_trig_q;
  assign del_trig  = del_trig_q;
  assign adc_run   = adc_run_q;
  assign halt      = halt_q;
  assign tbl_wr_en = tbl_wr_en_q;
  assign tbl_sel   = tbl_sel_q;
  assign tbl_addr  = tbl_addr_q;
  assign tbl_data  = tbl_data_q;

`ifdef GPIO_WR_LOG_EN
  logic [15:0]       wr_count_q;
  logic [ADDR_W-1:0] last_addr_q;

  // Accepted-write log, updating in the same cycle wr_en is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_q  <= '0;
      last_addr_q <= '0;
    end else if (cap_edge) begin
      wr_count_q  <= wr_count_q + 16'd1;
      last_addr_q <= cap_addr;
    end
  end

  assign wr_count  = wr_count_q;
  assign last_addr = last_addr_q;
`else
  assign wr_count  = '0;
  assign last_addr = '0;
`endif

endmodule

// File: tb/tb_gpio_cfg_decoder.sv
// Self-checking bench for gpio_cfg_decoder: directed vector table, hand
// sequences for reset corner cases, and randomized writes checked against
// a behavioural register-map model. Honours GPIO_WR_LOG_EN.
module tb_gpio_cfg_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [24:0] gpio_in;
  logic        wr_en, run_trig, del_trig, adc_run, halt, tbl_wr_en;
  logic [15:0] wr_addr, wr_count, last_addr;
  logic [7:0]  wr_data, tbl_addr, tbl_data;
  logic [2:0]  tbl_sel;

  gpio_cfg_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .GPIO_W      (25),
    .ADDR_W      (16),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .run_trig  (run_trig),
    .del_trig  (del_trig),
    .adc_run   (adc_run),
    .halt      (halt),
    .tbl_wr_en (tbl_wr_en),
    .tbl_sel   (tbl_sel),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .wr_count  (wr_count),
    .last_addr (last_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        run, del, adc, halt, twe;
    logic [2:0]  sel;
    logic [7:0]  taddr, tdata;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        run, del, adc, halt, twe;
    logic [2:0]  sel;
    logic [7:0]  taddr, tdata;
  } vec_t;

  function automatic vec_t mk_vec(input logic [15:0] a, input logic [7:0] d,
                                  input logic run, input logic del, input logic adc,
                                  input logic hlt, input logic twe, input logic [2:0] sel,
                                  input logic [7:0] ta, input logic [7:0] td);
    vec_t v;
    v.addr = a; v.data = d; v.run = run; v.del = del; v.adc = adc;
    v.halt = hlt; v.twe = twe; v.sel = sel; v.taddr = ta; v.tdata = td;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [15:0] tbl_ptr_reg [6];   // pointer-register address per table; data reg is +1
  logic [7:0]  m_ptr [6];
  logic        m_halt;
  logic [15:0] m_cnt;
  logic [15:0] m_last;

  task automatic model_reset();
    for (int t = 0; t < 6; t++) m_ptr[t] = 8'h00;
    m_halt = 1'b0;
    m_cnt  = 16'h0000;
    m_last = 16'h0000;
  endtask

  task automatic model_step(input logic [15:0] a, input logic [7:0] d, output exp_t e);
    e.addr = a; e.data = d;
    e.run  = (a == 16'h0000);
    e.del  = (a == 16'h0001);
    e.adc  = (a == 16'h0005);
    if (a == 16'h0002) m_halt = d[0];
    e.halt = m_halt;
    e.twe = 1'b0; e.sel = 3'd0; e.taddr = 8'h00; e.tdata = 8'h00;
    for (int t = 0; t < 6; t++) begin
      if (a == tbl_ptr_reg[t]) begin
        m_ptr[t] = d;
      end else if (a == tbl_ptr_reg[t] + 16'd1) begin
        e.twe   = 1'b1;
        e.sel   = 3'(t);
        e.taddr = m_ptr[t];
        e.tdata = d;
        m_ptr[t] = 8'((int'(m_ptr[t]) + 1) % 256);
      end
    end
    m_cnt  = m_cnt + 16'd1;
    m_last = a;
    e.cnt  = m_cnt;
    e.cyc  = 0;
  endtask

  exp_t exp_q[$];
  int   mon_strobes = 0;

  // One write: low phase with addr/data set up, then a one-cycle high phase.
  task automatic issue(input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk) gpio_in = {1'b0, e.data, e.addr};
    @(negedge clk) gpio_in = {1'b1, e.data, e.addr};
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk) gpio_in[24] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- output monitor ----------------
  initial begin : monitor
    exp_t        e;
    logic        t_halt;
    logic [2:0]  t_sel;
    logic [7:0]  t_addr, t_data;
    t_halt = 1'b0; t_sel = 3'd0; t_addr = 8'h00; t_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        t_halt = 1'b0; t_sel = 3'd0; t_addr = 8'h00; t_data = 8'h00;
        check("reset_quiet", 32'({wr_en, run_trig, del_trig, adc_run, tbl_wr_en}), 32'd0);
      end else if (wr_en) begin
        mon_strobes++;
        if (exp_q.size() == 0) begin
          check("spurious_wr_en_queue_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("latency", 32'(cyc - e.cyc), 32'(LATENCY));
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          check("run_trig", 32'(run_trig), 32'(e.run));
          check("del_trig", 32'(del_trig), 32'(e.del));
          check("adc_run", 32'(adc_run), 32'(e.adc));
          check("halt", 32'(halt), 32'(e.halt));
          check("tbl_wr_en", 32'(tbl_wr_en), 32'(e.twe));
          if (e.twe) begin
            t_sel = e.sel; t_addr = e.taddr; t_data = e.tdata;
          end
          check("tbl_sel", 32'(tbl_sel), 32'(t_sel));
          check("tbl_addr", 32'(tbl_addr), 32'(t_addr));
          check("tbl_data", 32'(tbl_data), 32'(t_data));
          t_halt = e.halt;
`ifdef GPIO_WR_LOG_EN
          check("wr_count", 32'(wr_count), 32'(e.cnt));
          check("last_addr", 32'(last_addr), 32'(e.addr));
`endif
        end
      end else begin
        check("idle_pulses", 32'({run_trig, del_trig, adc_run, tbl_wr_en}), 32'd0);
        check("idle_halt", 32'(halt), 32'(t_halt));
        check("idle_tbl_hold", {8'h00, 5'd0, tbl_sel, tbl_addr, tbl_data},
              {8'h00, 5'd0, t_sel, t_addr, t_data});
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  vec_t        vecs [16];
  logic [15:0] pool [16];

  initial begin : main
    exp_t        em;
    exp_t        e;
    int          s0;
    logic [15:0] a;
    logic [7:0]  d;

    tbl_ptr_reg[0] = 16'h0015; tbl_ptr_reg[1] = 16'h0027; tbl_ptr_reg[2] = 16'h001A;
    tbl_ptr_reg[3] = 16'h001F; tbl_ptr_reg[4] = 16'h000C; tbl_ptr_reg[5] = 16'h000F;
    model_reset();

    //                  addr      data   run  del  adc  halt twe  sel   taddr  tdata
    vecs[0]  = mk_vec(16'h0001, 8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[1]  = mk_vec(16'h0015, 8'hFE, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[2]  = mk_vec(16'h0016, 8'h11, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd0, 8'hFE, 8'h11);
    vecs[3]  = mk_vec(16'h0016, 8'h22, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd0, 8'hFF, 8'h22);
    vecs[4]  = mk_vec(16'h0016, 8'h33, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd0, 8'h00, 8'h33);
    vecs[5]  = mk_vec(16'h001F, 8'h05, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[6]  = mk_vec(16'h000D, 8'hAA, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd4, 8'h00, 8'hAA);
    vecs[7]  = mk_vec(16'h0020, 8'h77, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd3, 8'h05, 8'h77);
    vecs[8]  = mk_vec(16'h0002, 8'h01, 1'b0,1'b0,1'b0,1'b1,1'b0,3'd0, 8'h00, 8'h00);
    vecs[9]  = mk_vec(16'h0002, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[10] = mk_vec(16'h1234, 8'h5A, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[11] = mk_vec(16'h0000, 8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[12] = mk_vec(16'h0005, 8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd0, 8'h00, 8'h00);
    vecs[13] = mk_vec(16'h0028, 8'h3C, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd1, 8'h00, 8'h3C);
    vecs[14] = mk_vec(16'h0010, 8'hC3, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd5, 8'h00, 8'hC3);
    vecs[15] = mk_vec(16'h001B, 8'h01, 1'b0,1'b0,1'b0,1'b0,1'b1,3'd2, 8'h00, 8'h01);

    pool[0]  = 16'h0000; pool[1]  = 16'h0001; pool[2]  = 16'h0002; pool[3]  = 16'h0005;
    pool[4]  = 16'h0015; pool[5]  = 16'h0016; pool[6]  = 16'h0027; pool[7]  = 16'h0028;
    pool[8]  = 16'h001A; pool[9]  = 16'h001B; pool[10] = 16'h001F; pool[11] = 16'h0020;
    pool[12] = 16'h000C; pool[13] = 16'h000D; pool[14] = 16'h000F; pool[15] = 16'h0010;

    // Reset with w_clk already high.
    rst     = 1'b0;
    gpio_in = {1'b1, 8'h00, 16'h0001};
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_pulses", 32'({run_trig, del_trig, adc_run}), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_tbl", {7'd0, tbl_wr_en, 5'd0, tbl_sel, tbl_addr, tbl_data}, 32'd0);
    check("rst_log", {wr_count, last_addr}, 32'd0);

    // Release with w_clk held high: no write may appear.
    @(negedge clk) rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_write_wclk_high_at_release", 32'(mon_strobes), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      model_step(vecs[i].addr, vecs[i].data, em);
      e       = em;
      e.run   = vecs[i].run;   e.del   = vecs[i].del;   e.adc = vecs[i].adc;
      e.halt  = vecs[i].halt;  e.twe   = vecs[i].twe;   e.sel = vecs[i].sel;
      e.taddr = vecs[i].taddr; e.tdata = vecs[i].tdata;
      issue(e);
      if (i < 2) idle(3);
    end
    drain();

    // Reset while a write is in flight.
    model_step(16'h0002, 8'h01, em); issue(em);
    model_step(16'h001A, 8'h40, em); issue(em);
    drain();
    s0 = mon_strobes;
    @(negedge clk) gpio_in = {1'b0, 8'h99, 16'h001B};
    @(negedge clk) gpio_in = {1'b1, 8'h99, 16'h001B};
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_halt", 32'(halt), 32'd0);
    check("midrst_tbl_addr", 32'(tbl_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_strobe", 32'(mon_strobes - s0), 32'd0);

    // Back-to-back burst of 10: first two read the pointers back after reset.
    s0 = mon_strobes;
    model_step(16'h001B, 8'h12, em); issue(em);
    model_step(16'h0016, 8'h34, em); issue(em);
    for (int i = 0; i < 8; i++) begin
      a = pool[$urandom_range(0, 15)];
      d = 8'($urandom);
      model_step(a, d, em);
      issue(em);
    end
    drain();
    check("burst_strobes", 32'(mon_strobes - s0), 32'd10);
`ifdef GPIO_WR_LOG_EN
    check("burst_wr_count", 32'(wr_count), 32'd10);
    check("burst_last_addr", 32'(last_addr), 32'(m_last));
`endif

    // Randomized writes with random gaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) a = pool[$urandom_range(0, 15)];
      else                           a = 16'($urandom);
      d = 8'($urandom);
      model_step(a, d, em);
      idle($urandom_range(0, 2));
      issue(em);
    end
    drain();

`ifdef GPIO_WR_LOG_EN
    check("final_wr_count", 32'(wr_count), 32'(m_cnt));
    check("final_last_addr", 32'(last_addr), 32'(m_last));
`else
    check("final_wr_count_tied", 32'(wr_count), 32'd0);
    check("final_last_addr_tied", 32'(last_addr), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
